// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus_responder slave: FSM state encodings,
// the idle (inactive) level of the active-low strobes and default widths.
package bus_responder_pkg;

   localparam int   DEFAULT_DATA_W = 8;
   localparam int   DEFAULT_ADDR_W = 4;
   localparam logic STROBE_IDLE    = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_ADDR    = 3'b001,
      ST_ADDR_OK = 3'b010,
      ST_WRITE   = 3'b011,
      ST_READ    = 3'b100,
      ST_ERR     = 3'b111
   } resp_state_e;

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flip-flop synchronizer for asynchronous pad inputs; the reset
// value is a parameter so strobes can come out of reset at their idle level.
module bus_sync #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Fewer than two stages would not give metastability protection.
   localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/bus_responder.sv
// Responder end of the multiplexed address/data strobe bus with an internal
// register file. Define BUS_RESP_PROTO_CHK_EN to add the sticky proto_err output.
module bus_responder
   import bus_responder_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int ADDR_W      = DEFAULT_ADDR_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CS,
   input  logic              RD,
   input  logic              WR,
   input  logic              AD,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic [2:0]        state,
   output logic              wr_pulse,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
`ifdef BUS_RESP_PROTO_CHK_EN
   output logic              proto_err,
`endif
   input  logic [ADDR_W-1:0] host_addr,
   output logic [DATA_W-1:0] host_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic              s_cs, s_rd, s_wr, s_ad;
   logic [DATA_W-1:0] s_bus;

   resp_state_e       state_q, state_d;
   logic [DATA_W-1:0] dreg_q, dreg_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              in_range_q, in_range_d;
   logic [DATA_W-1:0] bus_out_q, bus_out_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic              commit;
   logic [DATA_W-1:0] read_val;

   // Strobes leave reset inactive so the FSM does not see a phantom address phase.
   bus_sync #(
      .WIDTH     (4),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL ({STROBE_IDLE, STROBE_IDLE, STROBE_IDLE, 1'b0})
   ) u_sync_strobe (
      .clk   (clk),
      .reset (reset),
      .din   ({CS, RD, WR, AD}),
      .dout  ({s_cs, s_rd, s_wr, s_ad})
   );

   bus_sync #(
      .WIDTH     (DATA_W),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL ('0)
   ) u_sync_bus (
      .clk   (clk),
      .reset (reset),
      .din   (bus_in),
      .dout  (s_bus)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!s_cs && !s_wr && !s_ad) begin
               state_d = ST_ADDR;
            end else if (!s_cs && s_ad) begin
               state_d = ST_ERR;
            end
         end
         ST_ADDR: begin
            if (s_wr) begin
               state_d = ST_ADDR_OK;
            end else if (s_cs) begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR_OK: begin
            if (!s_rd && !s_wr) begin
               state_d = ST_ERR;
            end else if (!s_cs && !s_ad && !s_wr) begin
               state_d = ST_ADDR;
            end else if (!s_cs && s_ad && !s_wr && s_rd) begin
               state_d = ST_WRITE;
            end else if (!s_cs && s_ad && !s_rd && s_wr) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE: begin
            if (s_cs || s_wr) begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (s_cs || s_rd) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR: begin
            if (s_cs && s_rd && s_wr) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      commit   = (state_q == ST_WRITE) && !s_cs && s_wr && in_range_q;
      read_val = in_range_q ? regs_q[addr_q] : '0;
      bus_oe   = (state_q == ST_READ) && !s_cs && !s_rd;
      bus_out  = bus_oe ? read_val : bus_out_q;
      wr_pulse = commit;
      wr_addr  = addr_q;
      wr_data  = dreg_q;
      state    = state_q;
   end

   // Address latches on the rising write strobe that closes the address phase.
   always_comb begin
      dreg_d     = s_wr ? dreg_q : s_bus;
      addr_d     = addr_q;
      in_range_d = in_range_q;
      if ((state_q == ST_ADDR) && s_wr) begin
         addr_d     = dreg_q[ADDR_W-1:0];
         in_range_d = (dreg_q[DATA_W-1:ADDR_W] == '0);
      end
      bus_out_d = bus_out;
      regs_d    = regs_q;
      if (commit) begin
         regs_d[addr_q] = dreg_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dreg_q     <= '0;
         addr_q     <= '0;
         in_range_q <= 1'b0;
         bus_out_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         dreg_q     <= dreg_d;
         addr_q     <= addr_d;
         in_range_q <= in_range_d;
         bus_out_q  <= bus_out_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // A same-cycle bus commit becomes visible here only after the clock edge.
   assign host_data = regs_q[host_addr];

`ifdef BUS_RESP_PROTO_CHK_EN
   logic proto_err_q, proto_err_d;

   always_comb begin
      proto_err_d = proto_err_q;
      if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
         proto_err_d = 1'b1;
      end
      if (((state_q == ST_WRITE) || (state_q == ST_READ)) && !in_range_q) begin
         proto_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_bus_responder.sv
// Directed, table-driven bench for bus_responder: bus write/read transactions,
// out-of-range addresses, protocol errors, reset mid-write and back-to-back traffic.
module tb_bus_responder;

   localparam int DATA_W      = 8;
   localparam int ADDR_W      = 4;
   localparam int SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              CS = 1'b1;
   logic              RD = 1'b1;
   logic              WR = 1'b1;
   logic              AD = 1'b0;
   logic [DATA_W-1:0] bus_in = '0;
   logic [DATA_W-1:0] bus_out;
   logic              bus_oe;
   logic [2:0]        state;
   logic              wr_pulse;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_data;
`ifdef BUS_RESP_PROTO_CHK_EN
   logic              proto_err;
`endif

   int                checks = 0;
   int                failures = 0;
   int                pulseCount = 0;
   int                oeViolations = 0;
   logic [ADDR_W-1:0] lastPulseAddr = '0;
   logic [DATA_W-1:0] lastPulseData = '0;

   typedef struct {
      logic              isWrite;
      logic [DATA_W-1:0] busAddr;
      logic [DATA_W-1:0] data;
      int                expPulses;
      logic [ADDR_W-1:0] hostAddr;
      logic [DATA_W-1:0] expHost;
      logic [DATA_W-1:0] expRead;
   } vec_t;

   vec_t vecs[37];

   bus_responder #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .CS        (CS),
      .RD        (RD),
      .WR        (WR),
      .AD        (AD),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .bus_oe    (bus_oe),
      .state     (state),
      .wr_pulse  (wr_pulse),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
`ifdef BUS_RESP_PROTO_CHK_EN
      .proto_err (proto_err),
`endif
      .host_addr (host_addr),
      .host_data (host_data)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (wr_pulse) begin
            pulseCount++;
            lastPulseAddr = wr_addr;
            lastPulseData = wr_data;
         end
         if (bus_oe && (state != 3'b100)) begin
            oeViolations++;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addressPhase(input logic [DATA_W-1:0] a);
      CS = 1'b0; AD = 1'b0; RD = 1'b1; WR = 1'b0; bus_in = a;
      tick(4);
      WR = 1'b1;
      tick(3);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int p0;
      int lat;
      logic [DATA_W-1:0] rdata;
      p0 = pulseCount;
      addressPhase(v.busAddr);
      if (v.isWrite) begin
         AD = 1'b1; WR = 1'b0; bus_in = v.data;
         tick(4);
         WR = 1'b1;
         tick(4);
         CS = 1'b1; AD = 1'b0;
         tick(4);
         checkOutput($sformatf("v%0d pulse count", idx), pulseCount - p0, v.expPulses);
         if (v.expPulses > 0) begin
            checkOutput($sformatf("v%0d wr_addr", idx), lastPulseAddr, v.busAddr[ADDR_W-1:0]);
            checkOutput($sformatf("v%0d wr_data", idx), lastPulseData, v.data);
         end
      end else begin
         AD = 1'b1; RD = 1'b0; lat = 0;
         for (int k = 1; (k <= 10) && (lat == 0); k++) begin
            tick(1);
            if (bus_oe) lat = k;
         end
         checkOutput($sformatf("v%0d read latency", idx), lat, SYNC_STAGES + 1);
         tick(2);
         rdata = bus_out;
         checkOutput($sformatf("v%0d read data", idx), rdata, v.expRead);
         RD = 1'b1;
         tick(1);
         checkOutput($sformatf("v%0d oe before sRD high", idx), bus_oe, 1);
         tick(1);
         checkOutput($sformatf("v%0d oe drop", idx), bus_oe, 0);
         checkOutput($sformatf("v%0d bus_out hold", idx), bus_out, v.expRead);
         CS = 1'b1; AD = 1'b0;
         tick(4);
         checkOutput($sformatf("v%0d no pulse on read", idx), pulseCount - p0, 0);
      end
      host_addr = v.hostAddr;
      #1;
      checkOutput($sformatf("v%0d host_data", idx), host_data, v.expHost);
   endtask

   initial begin
      int p0;

      vecs[0] = '{1'b1, 8'h05, 8'hA7, 1, 4'h5, 8'hA7, 8'h00};
      vecs[1] = '{1'b0, 8'h05, 8'h00, 0, 4'h5, 8'hA7, 8'hA7};
      vecs[2] = '{1'b1, 8'h35, 8'h11, 0, 4'h5, 8'hA7, 8'h00};
      vecs[3] = '{1'b0, 8'h05, 8'h00, 0, 4'h5, 8'hA7, 8'hA7};
      vecs[4] = '{1'b0, 8'h35, 8'h00, 0, 4'h5, 8'hA7, 8'h00};
      for (int i = 0; i < 16; i++) begin
         vecs[5 + i]  = '{1'b1, 8'(i), 8'(240 + i), 1, 4'(i), 8'(240 + i), 8'h00};
         vecs[21 + i] = '{1'b0, 8'(i), 8'h00, 0, 4'(i), 8'(240 + i), 8'(240 + i)};
      end

      host_addr = 4'h5;
      tick(3);
      checkOutput("reset state", state, 3'b000);
      checkOutput("reset bus_oe", bus_oe, 0);
      checkOutput("reset bus_out", bus_out, 8'h00);
      checkOutput("reset wr_pulse", wr_pulse, 0);
      checkOutput("reset host_data", host_data, 8'h00);
      reset = 1'b1;
      tick(3);
      checkOutput("idle after release", state, 3'b000);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], i);
`ifdef BUS_RESP_PROTO_CHK_EN
         if (i == 1) checkOutput("proto_err clean", proto_err, 0);
         if (i == 2) checkOutput("proto_err out of range", proto_err, 1);
`endif
      end

      // Data phase with no preceding address phase.
      p0 = pulseCount;
      CS = 1'b0; AD = 1'b1;
      tick(3);
      checkOutput("no-addr data phase state", state, 3'b111);
      checkOutput("no-addr bus_oe", bus_oe, 0);
      CS = 1'b1; AD = 1'b0;
      tick(4);
      checkOutput("no-addr back to idle", state, 3'b000);

      // RD and WR both low after a valid address.
      addressPhase(8'h02);
      checkOutput("addr_ok reached", state, 3'b010);
      AD = 1'b1; RD = 1'b0; WR = 1'b0; bus_in = 8'h99;
      tick(3);
      checkOutput("rd+wr state", state, 3'b111);
      checkOutput("rd+wr bus_oe", bus_oe, 0);
      CS = 1'b1; RD = 1'b1; WR = 1'b1; AD = 1'b0;
      tick(4);
      checkOutput("rd+wr back to idle", state, 3'b000);
      checkOutput("protocol errors no pulse", pulseCount - p0, 0);
      host_addr = 4'h2;
      #1;
      checkOutput("rd+wr reg untouched", host_data, 8'h00);
`ifdef BUS_RESP_PROTO_CHK_EN
      checkOutput("proto_err sticky", proto_err, 1);
`endif

      // Reset asserted while the write is pending.
      p0 = pulseCount;
      addressPhase(8'h03);
      AD = 1'b1; WR = 1'b0; bus_in = 8'h5A;
      tick(3);
      checkOutput("in write state", state, 3'b011);
      reset = 1'b0;
      #1;
      checkOutput("async reset state", state, 3'b000);
      checkOutput("async reset bus_oe", bus_oe, 0);
      for (int a = 0; a < 16; a++) begin
         host_addr = 4'(a);
         #0.1;
         checkOutput($sformatf("reset clears reg%0d", a), host_data, 8'h00);
      end
      CS = 1'b1; WR = 1'b1; AD = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(6);
      checkOutput("no pulse across reset", pulseCount - p0, 0);
      checkOutput("idle after mid-write reset", state, 3'b000);
`ifdef BUS_RESP_PROTO_CHK_EN
      checkOutput("proto_err cleared by reset", proto_err, 0);
`endif

      p0 = pulseCount;
      for (int i = 5; i < 37; i++) begin
         applyStimulus(vecs[i], i);
      end
      checkOutput("back-to-back total pulses", pulseCount - p0, 16);
      checkOutput("bus_oe only in READ", oeViolations, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
